// File: rtl/uart_frame_decoder_if.sv
// uart_frame_decoder_if
// Word stream from the UART receiver into the frame decoder.
//   word_in     16  received word, meaningful only while word_valid=1
//   word_valid   1  one-cycle strobe per received word
// Modports: master = UART side (drives), slave = decoder side (samples).
interface uart_frame_decoder_if;
   logic [15:0] word_in;
   logic        word_valid;

   modport master (output word_in, output word_valid);
   modport slave  (input  word_in, input  word_valid);
endinterface

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Hunts for SYNC_WORD in the UART word stream and assembles a 7-word game-state frame
// (ball position, player-1 position, scores, flags). Each data word carries a 4-bit tag
// equal to its index, and the last word is the XOR of words 1..5. A good frame is held
// as "pending" and copied to the outputs on the vblnk rising edge, so the drawers never
// see a half-updated state.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   uart              word_in / word_valid stream (slave modport)
//   vblnk_in          vertical blank from vga_timing
//   ball_posx/y       committed ball position (12 bits each)
//   pl1_posx/y        committed player-1 position (12 bits each)
//   pl1/pl2_score     committed scores (4 bits each)
//   flag_point        committed last-touch flag
//   end_game          committed end-of-game flag
//   whistle_play      one-cycle pulse on a commit whose frame has the whistle bit set
//   frame_ok          one-cycle pulse when a frame passes the checksum
//   frame_err         one-cycle pulse on tag, checksum, timeout or resync error
//   err_count         saturating error counter
module uart_frame_decoder #(
   parameter logic [15:0] SYNC_WORD       = 16'hA55A,
   parameter int unsigned TIMEOUT_CYC     = 65000,
   parameter bit          COMMIT_ON_VBLNK = 1'b1,
   parameter logic [11:0] BALL_X0         = 12'd256,
   parameter logic [11:0] BALL_Y0         = 12'd200,
   parameter logic [11:0] PL1_X0          = 12'd974,
   parameter logic [11:0] PL1_Y0          = 12'd679
) (
   input  logic                       clk,
   input  logic                       rst_n,
   uart_frame_decoder_if.slave        uart,
   input  logic                       vblnk_in,
   output logic [11:0]                ball_posx,
   output logic [11:0]                ball_posy,
   output logic [11:0]                pl1_posx,
   output logic [11:0]                pl1_posy,
   output logic [3:0]                 pl1_score,
   output logic [3:0]                 pl2_score,
   output logic                       flag_point,
   output logic                       end_game,
   output logic                       whistle_play,
   output logic                       frame_ok,
   output logic                       frame_err,
   output logic [7:0]                 err_count
);

   localparam int unsigned IdleW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {StHunt, StRecv, StCsum} state_e;

   typedef struct packed {
      logic [11:0] ball_x;
      logic [11:0] ball_y;
      logic [11:0] pl1_x;
      logic [11:0] pl1_y;
      logic [3:0]  pl1_score;
      logic [3:0]  pl2_score;
      logic        whistle;
      logic        end_game;
      logic        flag_point;
   } frame_t;

   localparam frame_t OutRst = '{
      ball_x: BALL_X0, ball_y: BALL_Y0, pl1_x: PL1_X0, pl1_y: PL1_Y0,
      pl1_score: 4'd0, pl2_score: 4'd0, whistle: 1'b0, end_game: 1'b0, flag_point: 1'b0
   };

   state_e            state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [15:0]       acc_q, acc_d;
   logic [IdleW-1:0]  idle_q, idle_d;
   frame_t            shadow_q, shadow_d;
   frame_t            pending_q, pending_d;
   logic              pend_vld_q, pend_vld_d;
   frame_t            stage_q, stage_d;
   logic              stage_vld_q, stage_vld_d;
   frame_t            out_q, out_d;
   logic              vblnk_q;
   logic              whistle_q, whistle_d;
   logic              frame_ok_q, frame_err_q;
   logic [7:0]        err_count_q, err_count_d;

   logic              frame_good, frame_bad;
   logic              vblnk_rise, trigger;

   // Frame-assembly FSM
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      idle_d     = idle_q;
      shadow_d   = shadow_q;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      unique case (state_q)
         StHunt: begin
            idle_d = '0;
            if (uart.word_valid && uart.word_in == SYNC_WORD) begin
               state_d = StRecv;
               idx_d   = 3'd1;
               acc_d   = '0;
            end
         end
         StRecv: begin
            if (uart.word_valid) begin
               idle_d = '0;
               if (uart.word_in == SYNC_WORD) begin
                  // Resync: a fresh sync word restarts the frame in place.
                  idx_d     = 3'd1;
                  acc_d     = '0;
                  frame_bad = 1'b1;
               end else if (uart.word_in[15:12] != {1'b0, idx_q}) begin
                  frame_bad = 1'b1;
                  state_d   = StHunt;
               end else begin
                  acc_d = acc_q ^ uart.word_in;
                  idx_d = idx_q + 3'd1;
                  case (idx_q)
                     3'd1: shadow_d.ball_x = uart.word_in[11:0];
                     3'd2: shadow_d.ball_y = uart.word_in[11:0];
                     3'd3: shadow_d.pl1_x  = uart.word_in[11:0];
                     3'd4: shadow_d.pl1_y  = uart.word_in[11:0];
                     3'd5: begin
                        shadow_d.pl1_score  = uart.word_in[11:8];
                        shadow_d.pl2_score  = uart.word_in[7:4];
                        shadow_d.whistle    = uart.word_in[2];
                        shadow_d.end_game   = uart.word_in[1];
                        shadow_d.flag_point = uart.word_in[0];
                        state_d             = StCsum;
                     end
                     default: ;
                  endcase
               end
            end else if (idle_q == IdleMax) begin
               frame_bad = 1'b1;
               state_d   = StHunt;
               idle_d    = '0;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         StCsum: begin
            if (uart.word_valid) begin
               idle_d  = '0;
               state_d = StHunt;
               if (uart.word_in == acc_q) frame_good = 1'b1;
               else                       frame_bad  = 1'b1;
            end else if (idle_q == IdleMax) begin
               frame_bad = 1'b1;
               state_d   = StHunt;
               idle_d    = '0;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         default: state_d = StHunt;
      endcase
   end

   // Commit path: the trigger snapshots pending into a stage register, and the stage is
   // copied to the outputs one clock later. Snapshotting first lets a frame that finishes
   // on the trigger cycle become the next pending frame without displacing the older one.
   assign vblnk_rise = vblnk_in & ~vblnk_q;
   assign trigger    = COMMIT_ON_VBLNK ? vblnk_rise : pend_vld_q;

   always_comb begin
      pending_d   = pending_q;
      pend_vld_d  = pend_vld_q;
      stage_d     = stage_q;
      stage_vld_d = 1'b0;
      out_d       = out_q;
      whistle_d   = 1'b0;
      err_count_d = err_count_q;
      if (trigger) begin
         stage_d     = pending_q;
         stage_vld_d = pend_vld_q;
         pend_vld_d  = 1'b0;
      end
      if (frame_good) begin
         pending_d  = shadow_q;
         pend_vld_d = 1'b1;
      end
      if (stage_vld_q) begin
         out_d     = stage_q;
         whistle_d = stage_q.whistle;
      end
      if (frame_bad && err_count_q != 8'hFF) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StHunt;
         idx_q       <= '0;
         acc_q       <= '0;
         idle_q      <= '0;
         shadow_q    <= '0;
         pending_q   <= '0;
         pend_vld_q  <= 1'b0;
         stage_q     <= '0;
         stage_vld_q <= 1'b0;
         out_q       <= OutRst;
         vblnk_q     <= 1'b1;  // no false edge if vblnk is already high out of reset
         whistle_q   <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         idle_q      <= idle_d;
         shadow_q    <= shadow_d;
         pending_q   <= pending_d;
         pend_vld_q  <= pend_vld_d;
         stage_q     <= stage_d;
         stage_vld_q <= stage_vld_d;
         out_q       <= out_d;
         vblnk_q     <= vblnk_in;
         whistle_q   <= whistle_d;
         frame_ok_q  <= frame_good;
         frame_err_q <= frame_bad;
         err_count_q <= err_count_d;
      end
   end

   assign ball_posx    = out_q.ball_x;
   assign ball_posy    = out_q.ball_y;
   assign pl1_posx     = out_q.pl1_x;
   assign pl1_posy     = out_q.pl1_y;
   assign pl1_score    = out_q.pl1_score;
   assign pl2_score    = out_q.pl2_score;
   assign flag_point   = out_q.flag_point;
   assign end_game     = out_q.end_game;
   assign whistle_play = whistle_q;
   assign frame_ok     = frame_ok_q;
   assign frame_err    = frame_err_q;
   assign err_count    = err_count_q;

endmodule
